// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, port id type and sizing helper for the
// two-port SRAM arbiter/controller.
package sram_ctrl_pkg;

   localparam int NUM_PORTS = 2;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'd0;
   localparam state_t SETUP   = 2'd1;
   localparam state_t ACCESS  = 2'd2;
   localparam state_t RECOVER = 2'd3;

   typedef logic port_id_t;

   // The down-counter needs at least one bit even when there are no wait states.
   function automatic int unsigned wait_cnt_width(input int unsigned wait_states);
      return (wait_states == 0) ? 1 : $clog2(wait_states + 1);
   endfunction

endpackage

// File: rtl/sram_arb.sv
// sram_arb: combinational two-port grant. With SRAM_ARB_ROUND_ROBIN_EN defined it also
// holds the round-robin pointer; otherwise port 0 has fixed priority.
module sram_arb
   import sram_ctrl_pkg::*;
(
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 update_i,
`endif
   input  logic [NUM_PORTS-1:0] req_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output port_id_t             gnt_id_o
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   // ptr_q names the port that wins the next tie.
   port_id_t ptr_q;
   port_id_t ptr_d;

   always_comb begin
      gnt_id_o = 1'b0;
      if (req_i[0] && req_i[1]) begin
         gnt_id_o = ptr_q;
      end else if (req_i[1]) begin
         gnt_id_o = 1'b1;
      end
      ptr_d = ptr_q;
      if (update_i && (|req_i)) begin
         ptr_d = ~gnt_id_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      gnt_id_o = !req_i[0];
   end
`endif

   always_comb begin
      gnt_o = '0;
      if (|req_i) begin
         gnt_o[gnt_id_o] = 1'b1;
      end
   end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// sram_arbiter_ctrl: shares one 62256-class async SRAM between two requesters and sequences
// ce_n/oe_n/we_n with WAIT_STATES extra access cycles. Optional macro: SRAM_ARB_ROUND_ROBIN_EN.
module sram_arbiter_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 15,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [NUM_PORTS-1:0]            req_valid,
   output logic [NUM_PORTS-1:0]            req_ready,
   input  logic [NUM_PORTS-1:0]            req_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*8-1:0]          req_wdata,
   output logic [NUM_PORTS-1:0]            resp_valid,
   output logic [7:0]                      resp_rdata,
   output logic [ADDR_WIDTH-1:0]           sram_addr,
   output logic [7:0]                      sram_data_out,
   output logic                            sram_data_oe,
   input  logic [7:0]                      sram_data_in,
   output logic                            sram_ce_n,
   output logic                            sram_oe_n,
   output logic                            sram_we_n
);

   localparam int unsigned CntW = wait_cnt_width(WAIT_STATES);

   state_t                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   we_q, we_d;
   port_id_t               id_q, id_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [7:0]             wdata_q, wdata_d;
   logic [7:0]             rdata_q, rdata_d;
   logic                   ce_n_q, ce_n_d;
   logic                   oe_n_q, oe_n_d;
   logic                   we_n_q, we_n_d;
   logic                   data_oe_q, data_oe_d;
   logic [NUM_PORTS-1:0]   resp_valid_q, resp_valid_d;
   // Low while reset is held so req_ready cannot echo req_valid through the reset window.
   logic                   run_q;

   logic [NUM_PORTS-1:0]   gnt;
   port_id_t               gnt_id;
   logic                   accept;
   logic                   gnt_we;
   logic [ADDR_WIDTH-1:0]  gnt_addr;
   logic [7:0]             gnt_wdata;

   sram_arb u_arb (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .update_i (accept),
`endif
      .req_i    (req_valid),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   assign accept    = (state_q == IDLE) && run_q && (|req_valid);
   assign req_ready = accept ? gnt : '0;

   always_comb begin
      gnt_we    = req_we[0];
      gnt_addr  = req_addr[ADDR_WIDTH-1:0];
      gnt_wdata = req_wdata[7:0];
      if (gnt_id) begin
         gnt_we    = req_we[1];
         gnt_addr  = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
         gnt_wdata = req_wdata[15:8];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      id_d    = id_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SETUP;
               we_d    = gnt_we;
               id_d    = gnt_id;
               addr_d  = gnt_addr;
               wdata_d = gnt_wdata;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CntW'(WAIT_STATES);
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = RECOVER;
               if (!we_q) begin
                  rdata_d = sram_data_in;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RECOVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes are registered from the next state so the pins never glitch on decode.
   always_comb begin
      ce_n_d       = !((state_d == SETUP) || (state_d == ACCESS));
      oe_n_d       = !((state_d == ACCESS) && !we_d);
      we_n_d       = !((state_d == ACCESS) && we_d);
      data_oe_d    = we_d && (state_d != IDLE);
      resp_valid_d = '0;
      if (state_d == RECOVER) begin
         resp_valid_d[id_d] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         id_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         data_oe_q    <= 1'b0;
         resp_valid_q <= '0;
         run_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         id_q         <= id_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         ce_n_q       <= ce_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         data_oe_q    <= data_oe_d;
         resp_valid_q <= resp_valid_d;
         run_q        <= 1'b1;
      end
   end

   assign sram_addr     = addr_q;
   assign sram_data_out = wdata_q;
   assign sram_data_oe  = data_oe_q;
   assign sram_ce_n     = ce_n_q;
   assign sram_oe_n     = oe_n_q;
   assign sram_we_n     = we_n_q;
   assign resp_valid    = resp_valid_q;
   assign resp_rdata    = rdata_q;

   assert property (@(posedge clock) disable iff (!reset_n) !(!sram_oe_n && !sram_we_n));
   assert property (@(posedge clock) disable iff (!reset_n) !(sram_data_oe && !sram_oe_n));
   assert property (@(posedge clock) disable iff (!reset_n)
                    !sram_ce_n |=> (sram_ce_n || $stable(sram_addr)));
   assert property (@(posedge clock) disable iff (!reset_n) $onehot0(req_ready));
   assert property (@(posedge clock) disable iff (!reset_n)
                    (|req_ready) |-> (state_q == IDLE));

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// tb_sram_arbiter_ctrl: table vectors, arbitration sequences, reset abort and a randomized
// run against a transaction-level model of the controller and a behavioural SRAM.
module tb_sram_arbiter_ctrl;

   parameter int WS = 1;
   localparam int AW = 15;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [1:0]      req_we = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [15:0]     req_wdata = '0;
   logic [1:0]      resp_valid;
   logic [7:0]      resp_rdata;
   logic [AW-1:0]   sram_addr;
   logic [7:0]      sram_data_out;
   logic            sram_data_oe;
   logic [7:0]      sram_data_in;
   logic            sram_ce_n;
   logic            sram_oe_n;
   logic            sram_we_n;

   always #5 clock = ~clock;

   sram_arbiter_ctrl #(
      .ADDR_WIDTH  (AW),
      .WAIT_STATES (WS)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .sram_addr     (sram_addr),
      .sram_data_out (sram_data_out),
      .sram_data_oe  (sram_data_oe),
      .sram_data_in  (sram_data_in),
      .sram_ce_n     (sram_ce_n),
      .sram_oe_n     (sram_oe_n),
      .sram_we_n     (sram_we_n)
   );

   // Behavioural SRAM: reads drive only while selected and output-enabled.
   logic [7:0] sram_mem [0:32767];
   logic [7:0] ref_mem  [0:32767];
   assign sram_data_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'hC3;
   always @(negedge clock) begin
      if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_data_out;
   end

   int         n_checks = 0;
   int         n_pass = 0;
   int         prefer = 0;
   logic [7:0] last_rd = '0;
   bit         last_known = 1'b1;
   int         grant_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   // Per-cycle strobe and handshake invariants.
   logic          mon_ce_n = 1'b1;
   logic [AW-1:0] mon_addr = '0;
   always begin
      @(negedge clock);
      #2;
      if (reset_n) begin
         chk("inv_oe_we", 32'(!(!sram_oe_n && !sram_we_n)), 1);
         chk("inv_doe_oe", 32'(!(sram_data_oe && !sram_oe_n)), 1);
         if (!sram_ce_n && !mon_ce_n) chk("inv_addr_stable", 32'(sram_addr), 32'(mon_addr));
         chk("inv_ready_onehot", 32'($onehot0(req_ready)), 1);
         if (req_ready != 2'b00) chk("inv_ready_idle", 32'(sram_ce_n && resp_valid == 2'b00), 1);
      end
      mon_ce_n = reset_n ? sram_ce_n : 1'b1;
      mon_addr = sram_addr;
   end

   task automatic do_reset();
      @(negedge clock);
      reset_n   = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clock);
      reset_n    = 1'b1;
      prefer     = 0;
      last_rd    = '0;
      last_known = 1'b1;
      @(negedge clock);
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "_ce_n"}, 32'(sram_ce_n), 1);
      chk({nm, "_oe_n"}, 32'(sram_oe_n), 1);
      chk({nm, "_we_n"}, 32'(sram_we_n), 1);
      chk({nm, "_data_oe"}, 32'(sram_data_oe), 0);
      chk({nm, "_req_ready"}, 32'(req_ready), 0);
      chk({nm, "_resp_valid"}, 32'(resp_valid), 0);
   endtask

   // One transaction on one port; checks accept, latency, strobe widths and read data.
   task automatic xact(input int p, input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                       input bit chk_data, input logic [7:0] exp, input string nm);
      int n;
      int lat;
      int we_lo;
      int oe_lo;
      int doe_hi;
      @(negedge clock);
      req_valid[p]           = 1'b1;
      req_we[p]              = we;
      req_addr[p*AW +: AW]   = a;
      req_wdata[p*8 +: 8]    = d;
      #1;
      n = 0;
      while (!req_ready[p] && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk({nm, "_accept"}, 32'(req_ready[p]), 1);
      if (req_ready[p]) begin
         prefer = 1 - p;
         @(posedge clock);
         #1 req_valid[p] = 1'b0;
         lat = 0; we_lo = 0; oe_lo = 0; doe_hi = 0;
         do begin
            @(negedge clock);
            #1;
            lat++;
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (sram_data_oe) doe_hi++;
         end while (!resp_valid[p] && lat < 50);
         chk({nm, "_latency"}, 32'(lat), 32'(3 + WS));
         chk({nm, "_we_low"}, 32'(we_lo), we ? 32'(WS + 1) : 0);
         chk({nm, "_oe_low"}, 32'(oe_lo), we ? 0 : 32'(WS + 1));
         chk({nm, "_data_oe"}, 32'(doe_hi), we ? 32'(WS + 3) : 0);
         if (we) begin
            ref_mem[a] = d;
            if (last_known) chk({nm, "_rdata_hold"}, 32'(resp_rdata), 32'(last_rd));
         end else if (chk_data) begin
            chk({nm, "_rdata"}, 32'(resp_rdata), 32'(exp));
            last_rd    = exp;
            last_known = 1'b1;
         end else begin
            last_known = 1'b0;
         end
      end
   endtask

   // Cycle-level run checked against a transaction model: grant when idle and requested,
   // response 3+WS cycles after grant, next idle 4+WS cycles after grant.
   task automatic engine(input int ncyc, input int pr0, input int pr1, input bit fixed,
                         input string nm);
      bit            pend [2];
      bit            drop [2];
      bit            pwe  [2];
      logic [AW-1:0] pa   [2];
      logic [7:0]    pd   [2];
      int            cyc, next_idle, resp_at, resp_p, g, pr;
      bit            resp_rd;
      logic [7:0]    resp_d;
      logic [1:0]    exp_rdy, exp_rsp;
      grant_q.delete();
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0;
         drop[p] = 1'b0;
      end
      cyc = 0; next_idle = 0; resp_at = -1; resp_p = 0; resp_rd = 1'b0; resp_d = '0;
      while ((cyc < ncyc || pend[0] || pend[1] || cyc < next_idle) && cyc < ncyc + 200) begin
         @(negedge clock);
         for (int p = 0; p < 2; p++) begin
            if (drop[p]) begin
               req_valid[p] = 1'b0;
               drop[p]      = 1'b0;
            end
            pr = (p == 0) ? pr0 : pr1;
            if (!pend[p] && cyc < ncyc && int'($urandom_range(99)) < pr) begin
               pend[p] = 1'b1;
               if (fixed) begin
                  pwe[p] = 1'b0;
                  pa[p]  = (p == 0) ? 15'h0001 : 15'h7FFF;
                  pd[p]  = '0;
               end else begin
                  pwe[p] = 1'($urandom_range(1));
                  pa[p]  = ($urandom_range(1) != 0) ? AW'($urandom_range(15)) : AW'($urandom);
                  pd[p]  = 8'($urandom);
               end
               req_valid[p]         = 1'b1;
               req_we[p]            = pwe[p];
               req_addr[p*AW +: AW] = pa[p];
               req_wdata[p*8 +: 8]  = pd[p];
            end
         end
         #1;
         exp_rdy = '0;
         g = -1;
         if (cyc >= next_idle && (pend[0] || pend[1])) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            if (pend[0] && pend[1]) g = prefer;
            else g = pend[0] ? 0 : 1;
`else
            g = pend[0] ? 0 : 1;
`endif
            exp_rdy[g] = 1'b1;
         end
         exp_rsp = (cyc == resp_at) ? (2'b01 << resp_p) : 2'b00;
         chk({nm, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
         chk({nm, "_resp_valid"}, 32'(resp_valid), 32'(exp_rsp));
         if (cyc == resp_at) begin
            if (resp_rd) begin
               chk({nm, "_rdata"}, 32'(resp_rdata), 32'(resp_d));
               last_rd    = resp_d;
               last_known = 1'b1;
            end else if (last_known) begin
               chk({nm, "_rdata_hold"}, 32'(resp_rdata), 32'(last_rd));
            end
         end
         if (g >= 0) begin
            grant_q.push_back(g);
            prefer    = 1 - g;
            pend[g]   = 1'b0;
            drop[g]   = 1'b1;
            resp_at   = cyc + 3 + WS;
            resp_p    = g;
            resp_rd   = !pwe[g];
            resp_d    = ref_mem[pa[g]];
            if (pwe[g]) ref_mem[pa[g]] = pd[g];
            next_idle = cyc + 4 + WS;
         end
         cyc++;
      end
      @(negedge clock);
      req_valid = '0;
      chk({nm, "_drained"}, 32'({pend[0], pend[1]}), 0);
   endtask

   typedef struct {
      int            port;
      bit            we;
      logic [AW-1:0] addr;
      logic [7:0]    wdata;
      logic [7:0]    exp;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int n;
      int act;
      vecs[0] = '{0, 1'b1, 15'h0010, 8'hA5, 8'h00};
      vecs[1] = '{0, 1'b0, 15'h0010, 8'h00, 8'hA5};
      vecs[2] = '{1, 1'b1, 15'h7FFF, 8'h3C, 8'h00};
      vecs[3] = '{1, 1'b0, 15'h7FFF, 8'h00, 8'h3C};
      vecs[4] = '{0, 1'b1, 15'h0000, 8'hFF, 8'h00};
      vecs[5] = '{1, 1'b0, 15'h0000, 8'h00, 8'hFF};
      vecs[6] = '{0, 1'b1, 15'h0010, 8'h5A, 8'h00};
      vecs[7] = '{0, 1'b0, 15'h0010, 8'h00, 8'h5A};
      vecs[8] = '{1, 1'b0, 15'h7FFF, 8'h00, 8'h3C};
      for (int i = 0; i < 32768; i++) begin
         sram_mem[i] = 8'(i) ^ 8'h96;
         ref_mem[i]  = 8'(i) ^ 8'h96;
      end

      // Requests held during reset must not be acknowledged.
      req_valid = 2'b11;
      repeat (3) begin
         @(negedge clock);
         #1;
         check_idle("reset");
         chk("reset_rdata", 32'(resp_rdata), 0);
         chk("reset_addr", 32'(sram_addr), 0);
         chk("reset_data_out", 32'(sram_data_out), 0);
      end
      req_valid = 2'b00;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clock);
         #1;
         check_idle("idle");
      end

      for (int i = 0; i < 9; i++) begin
         xact(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, !vecs[i].we, vecs[i].exp,
              $sformatf("vec%0d", i));
      end

      // Both ports request continuously: priority or alternation, then port 1 drains.
      do_reset();
      engine(8 * (WS + 4), 100, 100, 1'b1, "contend");
      chk("contend_ngrants", 32'(grant_q.size()), 10);
      for (int i = 0; i < 10; i++) begin
         act = (i < grant_q.size()) ? grant_q[i] : 99;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         chk($sformatf("contend_grant%0d", i), 32'(act), 32'(i % 2));
`else
         chk($sformatf("contend_grant%0d", i), 32'(act), (i == 9) ? 1 : 0);
`endif
      end

      engine(400, 40, 40, 1'b0, "rand");
      engine(200, 80, 25, 1'b0, "rand_busy");

      // Reset in the middle of a write's ACCESS phase drops it without a response.
      @(negedge clock);
      req_valid[0]          = 1'b1;
      req_we[0]             = 1'b1;
      req_addr[AW-1:0]      = 15'h0123;
      req_wdata[7:0]        = 8'h77;
      #1;
      n = 0;
      while (!req_ready[0] && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("abort_accept", 32'(req_ready[0]), 1);
      @(posedge clock);
      #1 req_valid[0] = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #1;
      chk("abort_in_access", 32'(sram_we_n), 0);
      reset_n = 1'b0;
      #1;
      check_idle("abort");
      chk("abort_rdata", 32'(resp_rdata), 0);
      repeat (3) begin
         @(negedge clock);
         #1;
         chk("abort_no_resp", 32'(resp_valid), 0);
      end
      reset_n    = 1'b1;
      prefer     = 0;
      last_rd    = '0;
      last_known = 1'b1;
      @(negedge clock);
      xact(0, 1'b0, 15'h0123, 8'h00, 1'b0, 8'h00, "abort_read");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
